// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU arbiter slice.
//   XLEN_DEFAULT  - default operand/result width
//   alu_sig_e     - ALUSignal op codes driven to the shared ALU
//   OP_MAX_LEGAL  - highest legal op code; anything above is illegal
//   op_legal()    - legality test for a raw 5-bit op code
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int OP_W         = 5;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9
    } alu_sig_e;

    localparam logic [OP_W-1:0] OP_MAX_LEGAL = 5'd9;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_MAX_LEGAL;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundle of requester, response and shared-ALU signals.
//   req_*      - two requesters (0 = EX stage, 1 = branch/address unit)
//   rsp_*      - registered per-requester response slots
//   alu_*      - operands/op out to the shared ALU, combinational result back
// Modports: slave = arbiter side, master = requesters + ALU side.
interface alu_arbiter_if #(parameter int XLEN = alu_pkg::XLEN_DEFAULT);

    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [4:0]      req_op0;
    logic [4:0]      req_op1;
    logic [XLEN-1:0] req_a0;
    logic [XLEN-1:0] req_b0;
    logic [XLEN-1:0] req_a1;
    logic [XLEN-1:0] req_b1;

    logic [4:0]      alu_signal;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;

    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [1:0]      rsp_err;
    logic [XLEN-1:0] rsp_data0;
    logic [XLEN-1:0] rsp_data1;

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        input  alu_result, rsp_ready,
        output req_ready, alu_signal, alu_a, alu_b,
        output rsp_valid, rsp_err, rsp_data0, rsp_data1
    );

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        output alu_result, rsp_ready,
        input  req_ready, alu_signal, alu_a, alu_b,
        input  rsp_valid, rsp_err, rsp_data0, rsp_data1
    );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst_n  - clock, async active-low reset (pointer -> requester 0)
//   eligible    - per-requester eligibility
//   grant       - one-hot grant (or zero when nobody is eligible)
// The pointer names the preferred requester on a tie and always moves to
// the loser after a grant, so two continuous requesters alternate.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] eligible,
    output logic [1:0] grant
);

    logic ptr_q, ptr_d;

    always_comb begin
        grant = 2'b00;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase

        ptr_d = ptr_q;
        if (grant[0])      ptr_d = 1'b1;
        else if (grant[1]) ptr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   clk, rst_n - clock, async active-low reset
//   bus        - alu_arbiter_if slave: requests in, ALU op/operands out,
//                ALU result in, registered responses out
// One request is accepted per cycle; its ALU result is captured into that
// requester's response slot on the accept edge (1-cycle latency). Illegal
// op codes are accepted but never reach the ALU; they answer 0 with err set.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    logic [1:0]            eligible;
    logic [1:0]            grant;
    logic [1:0][OP_W-1:0]  req_op;
    logic [1:0][XLEN-1:0]  req_a;
    logic [1:0][XLEN-1:0]  req_b;

    logic                  sel_idx;
    logic                  sel_legal;
    logic [OP_W-1:0]       alu_signal;
    logic [XLEN-1:0]       alu_a;
    logic [XLEN-1:0]       alu_b;

    logic [1:0]            rsp_valid_q, rsp_valid_d;
    logic [1:0]            rsp_err_q,   rsp_err_d;
    logic [1:0][XLEN-1:0]  rsp_data_q,  rsp_data_d;

    assign req_op = {bus.req_op1, bus.req_op0};
    assign req_a  = {bus.req_a1,  bus.req_a0};
    assign req_b  = {bus.req_b1,  bus.req_b0};

    // A slot can take a new result if it is empty or being drained this
    // cycle. Gating with rst_n keeps req_ready low throughout reset.
    always_comb begin
        eligible = bus.req_valid & (~rsp_valid_q | bus.rsp_ready) & {2{rst_n}};
    end

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (eligible),
        .grant    (grant)
    );

    assign sel_idx   = grant[1];
    assign sel_legal = op_legal(req_op[sel_idx]);

    // ALU sees ADD 0,0 unless a legal op is granted.
    always_comb begin
        alu_signal = ALU_ADD;
        alu_a      = '0;
        alu_b      = '0;
        if (|grant && sel_legal) begin
            alu_signal = req_op[sel_idx];
            alu_a      = req_a[sel_idx];
            alu_b      = req_b[sel_idx];
        end
    end

    // Grant wins over consume so a drain + accept in one cycle keeps the
    // slot valid and loads the fresh result.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        for (int k = 0; k < 2; k++) begin
            if (grant[k]) begin
                rsp_valid_d[k] = 1'b1;
                rsp_err_d[k]   = ~sel_legal;
                rsp_data_d[k]  = sel_legal ? bus.alu_result : '0;
            end else if (bus.rsp_ready[k]) begin
                rsp_valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.req_ready  = grant;
    assign bus.alu_signal = alu_signal;
    assign bus.alu_a      = alu_a;
    assign bus.alu_b      = alu_b;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_data0  = rsp_data_q[0];
    assign bus.rsp_data1  = rsp_data_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios with literal expectations, then a
// randomized run, all shadowed by a cycle-level reference model that is
// compared against the DUT on every falling edge.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.XLEN(XLEN)) bus ();

    alu_arbiter #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural shared ALU.
    function automatic logic [31:0] alu_ref(input logic [4:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            5'd0: return a + b;
            5'd1: return a - b;
            5'd2: return a << b[4:0];
            5'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd4: return (a < b) ? 32'd1 : 32'd0;
            5'd5: return a ^ b;
            5'd6: return a >> b[4:0];
            5'd7: return $unsigned($signed(a) >>> b[4:0]);
            5'd8: return a | b;
            5'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    assign bus.alu_result = alu_ref(bus.alu_signal, bus.alu_a, bus.alu_b);

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model + compare process ----------------
    int          m_ptr;
    logic [1:0]  m_rv, m_re;
    logic [31:0] m_rd [2];

    initial begin
        int          g;
        int          n_ptr;
        logic [1:0]  n_rv, n_re;
        logic [31:0] n_rd [2];
        logic [4:0]  op [2];
        logic [31:0] av [2], bv [2];
        logic [1:0]  elig;
        logic [4:0]  e_sig;
        logic [31:0] e_a, e_b;
        logic [1:0]  p_hold;
        logic [4:0]  p_op [2];
        logic [31:0] p_a [2], p_b [2];

        m_ptr = 0; m_rv = '0; m_re = '0; m_rd[0] = '0; m_rd[1] = '0;
        p_hold = '0;
        n_ptr = 0; n_rv = '0; n_re = '0; n_rd[0] = '0; n_rd[1] = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_ptr = 0; m_rv = '0; m_re = '0; m_rd[0] = '0; m_rd[1] = '0;
                p_hold = '0;
                chk("rst_req_ready", bus.req_ready, 0);
                chk("rst_rsp_valid", bus.rsp_valid, 0);
                chk("rst_rsp_err",   bus.rsp_err, 0);
                chk("rst_rsp_data",  {bus.rsp_data1, bus.rsp_data0}, 0);
                n_ptr = 0; n_rv = '0; n_re = '0; n_rd[0] = '0; n_rd[1] = '0;
            end else begin
                op[0] = bus.req_op0; av[0] = bus.req_a0; bv[0] = bus.req_b0;
                op[1] = bus.req_op1; av[1] = bus.req_a1; bv[1] = bus.req_b1;

                for (int k = 0; k < 2; k++)
                    if (p_hold[k] && bus.req_valid[k])
                        chk("req_hold_stable", {op[k], av[k], bv[k]}, {p_op[k], p_a[k], p_b[k]});

                for (int k = 0; k < 2; k++)
                    elig[k] = bus.req_valid[k] && (!m_rv[k] || bus.rsp_ready[k]);
                if (elig == 2'b11)      g = m_ptr;
                else if (elig[0])       g = 0;
                else if (elig[1])       g = 1;
                else                    g = -1;

                e_sig = 0; e_a = 0; e_b = 0;
                if (g >= 0 && op[g] <= 5'd9) begin
                    e_sig = op[g]; e_a = av[g]; e_b = bv[g];
                end

                chk("req_ready",  bus.req_ready, (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00);
                chk("alu_signal", bus.alu_signal, e_sig);
                chk("alu_ops",    {bus.alu_a, bus.alu_b}, {e_a, e_b});
                chk("rsp_valid",  bus.rsp_valid, m_rv);
                chk("rsp_err",    bus.rsp_err, m_re);
                chk("rsp_data0",  bus.rsp_data0, m_rd[0]);
                chk("rsp_data1",  bus.rsp_data1, m_rd[1]);

                n_ptr = m_ptr; n_rv = m_rv; n_re = m_re; n_rd[0] = m_rd[0]; n_rd[1] = m_rd[1];
                for (int k = 0; k < 2; k++) begin
                    if (g == k) begin
                        n_rv[k] = 1'b1;
                        n_re[k] = (op[k] > 5'd9);
                        n_rd[k] = (op[k] > 5'd9) ? 32'd0 : alu_ref(op[k], av[k], bv[k]);
                    end else if (bus.rsp_ready[k]) begin
                        n_rv[k] = 1'b0;
                    end
                    p_hold[k] = bus.req_valid[k] && (g != k);
                    p_op[k] = op[k]; p_a[k] = av[k]; p_b[k] = bv[k];
                end
                if (g >= 0) n_ptr = 1 - g;
            end
            @(posedge clk);
            if (rst_n) begin
                m_ptr = n_ptr; m_rv = n_rv; m_re = n_re; m_rd[0] = n_rd[0]; m_rd[1] = n_rd[1];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int k, input logic v, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (k == 0) begin
            bus.req_valid[0] = v; bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
        end else begin
            bus.req_valid[1] = v; bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
        end
    endtask

    // Leaves the bench just after a rising edge with reset released.
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(0, 1'b0, 5'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 5'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] acc;

        bus.req_valid = '0; bus.rsp_ready = '0;
        drive(0, 1'b0, 5'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 5'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single-request latency: ADD 5+7.
        bus.rsp_ready = 2'b11;
        drive(0, 1'b1, ALU_ADD, 32'd5, 32'd7);
        @(negedge clk);
        chk("t1_req_ready",  bus.req_ready, 2'b01);
        chk("t1_alu_signal", bus.alu_signal, 0);
        chk("t1_alu_result", bus.alu_result, 32'd12);
        @(posedge clk); #1;
        drive(0, 1'b0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("t1_rsp_valid0", bus.rsp_valid[0], 1'b1);
        chk("t1_rsp_data0",  bus.rsp_data0, 32'd12);
        chk("t1_rsp_err",    bus.rsp_err, 2'b00);

        // Round-robin fairness: continuous SUB 10-3 on both.
        do_reset();
        bus.rsp_ready = 2'b11;
        drive(0, 1'b1, ALU_SUB, 32'd10, 32'd3);
        drive(1, 1'b1, ALU_SUB, 32'd10, 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_grant_alt", bus.req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i >= 2) begin
                chk("t2_rsp_data0", bus.rsp_data0, 32'd7);
                chk("t2_rsp_data1", bus.rsp_data1, 32'd7);
            end
            @(posedge clk); #1;
        end

        // Backpressure on requester 0; requester 1 keeps flowing.
        bus.rsp_ready = 2'b10;
        repeat (3) begin
            @(negedge clk);
            chk("t3_req_ready",  bus.req_ready, 2'b10);
            chk("t3_rsp_valid0", bus.rsp_valid[0], 1'b1);
            chk("t3_rsp_data0",  bus.rsp_data0, 32'd7);
            @(posedge clk); #1;
        end

        // Back-to-back on requester 0: drain pending SUB, then XOR.
        bus.rsp_ready = 2'b11;
        drive(1, 1'b0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("t4_req_ready_a", bus.req_ready, 2'b01);
        @(posedge clk); #1;
        drive(0, 1'b1, ALU_XOR, 32'hF0, 32'h0F);
        @(negedge clk);
        chk("t4_req_ready_b", bus.req_ready, 2'b01);
        chk("t4_rsp_valid_b", bus.rsp_valid[0], 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("t4_rsp_valid_c", bus.rsp_valid[0], 1'b1);
        chk("t4_rsp_data0",   bus.rsp_data0, 32'hFF);

        // Illegal op on requester 1.
        @(posedge clk); #1;
        drive(1, 1'b1, 5'd12, 32'h1234, 32'h5678);
        @(negedge clk);
        chk("t5_req_ready",  bus.req_ready, 2'b10);
        chk("t5_alu_signal", bus.alu_signal, 0);
        chk("t5_alu_ops",    {bus.alu_a, bus.alu_b}, 64'd0);
        @(posedge clk); #1;
        drive(1, 1'b0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("t5_rsp_valid1", bus.rsp_valid[1], 1'b1);
        chk("t5_rsp_data1",  bus.rsp_data1, 32'd0);
        chk("t5_rsp_err1",   bus.rsp_err[1], 1'b1);

        // Reset mid-grant; pointer is first moved to requester 1.
        @(posedge clk); #1;
        drive(0, 1'b1, ALU_ADD, 32'd1, 32'd2);
        @(negedge clk);
        chk("t6_pre_grant", bus.req_ready, 2'b01);
        @(posedge clk); #1;
        drive(1, 1'b1, ALU_ADD, 32'd3, 32'd4);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_rsp_valid", bus.rsp_valid, 2'b00);
        chk("t6_rst_req_ready", bus.req_ready, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_grant",     bus.req_ready, 2'b01);
        chk("t6_post_rsp_valid", bus.rsp_valid, 2'b00);

        // Randomized traffic; a pending request is held until accepted.
        do_reset();
        acc = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                if (!(bus.req_valid[k] && !acc[k])) begin
                    logic [4:0]  rop;
                    logic [31:0] ra, rb;
                    rop = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(10, 31))
                                                      : 5'($urandom_range(0, 9));
                    ra  = $urandom;
                    rb  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                    drive(k, ($urandom_range(0, 9) < 7), rop, ra, rb);
                end
            end
            bus.rsp_ready = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with no other clock or reset inputs.
REQ-002 Parameter XLEN, default 32, SHALL set the operand and result width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid[1:0]  input  2  per-requester operation request (0 = EX stage, 1 = branch/address unit).
REQ-006 req_ready[1:0]  output  2  per-requester grant, high in the accept cycle.
REQ-007 req_op0, req_op1  input  5 each  ALUSignal code (ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9).
REQ-008 req_a0, req_b0, req_a1, req_b1  input  XLEN each  operands.
REQ-009 alu_signal  output  5  op code driven to the shared ALU.
REQ-010 alu_a, alu_b  output  XLEN each  operands driven to the shared ALU.
REQ-011 alu_result  input  XLEN  combinational result from the shared ALU, same cycle.
REQ-012 rsp_valid[1:0]  output  2  per-requester response held.
REQ-013 rsp_ready[1:0]  input  2  per-requester response consume.
REQ-014 rsp_data0, rsp_data1  output  XLEN each  registered results.
REQ-015 rsp_err[1:0]  output  2  response carries an illegal-op flag.

Function
REQ-016 Requester k SHALL be eligible when req_valid[k] is high and (rsp_valid[k] is low or rsp_ready[k] is high).
REQ-017 At most one req_ready bit SHALL be high per cycle.
REQ-018 Granting: a single eligible requester SHALL always be granted; when both are eligible, the requester named by the 1-bit round-robin pointer SHALL be granted.
REQ-019 After every grant the pointer SHALL point to the non-granted requester; with no grant it SHALL hold.
REQ-020 In a grant cycle, alu_signal, alu_a and alu_b SHALL equal the granted requester's op and operands combinationally.
REQ-021 With no grant, alu_signal SHALL be 0 (ADD) and alu_a and alu_b SHALL be 0.
REQ-022 On the grant edge, rsp_data[k] SHALL capture alu_result and rsp_valid[k] SHALL set, giving 1-cycle latency from accept to response.
REQ-023 An op code above 9 SHALL be accepted without being driven to the ALU (alu_signal = 0, operands 0).
REQ-024 For such an op, the response SHALL carry rsp_data = 0 and rsp_err[k] = 1; otherwise rsp_err[k] = 0.
REQ-025 rsp_valid[k] SHALL clear on a cycle with rsp_ready[k] high and no new grant to k.
REQ-026 Consume and a new grant to k in the same cycle SHALL leave rsp_valid[k] set and load the new result (back-to-back, full throughput per requester).
REQ-027 rsp_data and rsp_err SHALL remain stable while rsp_valid is high and rsp_ready is low.
REQ-028 A requester with a stalled response slot SHALL NOT block the other requester.
REQ-029 Requesters SHALL hold op and operands stable while req_valid is high and req_ready is low; the bench SHALL assert this.

Reset
REQ-030 On rst_n low, the block SHALL immediately clear rsp_valid, rsp_err and rsp_data to 0 and set the pointer to requester 0.
REQ-031 An operation accepted in the same cycle that reset asserts SHALL be discarded and produce no response.
REQ-032 req_ready SHALL be 0 while rst_n is low.

Structure
REQ-033 The ALUSignal code constants, the ILLEGAL-op bound (9) and the XLEN default SHALL live in the shared package alu_pkg.
REQ-034 Two-way round-robin selection SHALL be a sub-module, rr_arb2 (inputs: eligible[1:0]; outputs: one-hot grant[1:0]; internal pointer).

Verification
REQ-035 Single-request latency: req0 ADD a=5, b=7 alone -> req_ready[0] high that cycle, alu_signal = 0; next cycle rsp_valid[0] = 1, rsp_data0 = 12, rsp_err = 0.
REQ-036 Round-robin fairness: both requesters issue continuous SUB 10-3 with rsp_ready = 1 after reset -> grants alternate 0,1,0,1; each rsp_data = 7.
REQ-037 Backpressure: rsp_ready[0] = 0 while rsp_valid[0] = 1 and req0 valid -> req_ready[0] stays 0, rsp_data0 stable, requester 1 still granted each cycle.
REQ-038 Back-to-back: rsp_ready[0] = 1 with req0 XOR 0xF0 ^ 0x0F -> rsp_valid[0] stays 1, rsp_data0 updates to 0xFF next cycle.
REQ-039 Illegal op: req1 op = 12 -> accepted, ALU sees op 0 with operands 0, rsp_data1 = 0, rsp_err[1] = 1.
REQ-040 Reset mid-operation: rst_n low in a grant cycle -> all rsp_valid = 0 immediately; after release, the first simultaneous request is granted to requester 0.
